// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared CPU datapath types (word, ALU opcode, loader state)
// Rev 1.0
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8
  } aluop_t;

  // Encoding is shown on LEDG, so values are fixed 0..6.
  typedef enum logic [2:0] {
    ST_A_LO = 3'd0,
    ST_A_HI = 3'd1,
    ST_B_LO = 3'd2,
    ST_B_HI = 3'd3,
    ST_OP   = 3'd4,
    ST_EXEC = 3'd5,
    ST_SHOW = 3'd6
  } loader_state_t;

  localparam int c_FLAG_W = 3;

endpackage
`default_nettype wire

// File: rtl/alu_operand_loader_if.sv
`default_nettype none
// ============================================================================
// alu_operand_loader_if : operand/opcode bus between loader and ALU
// Rev 1.0
// ============================================================================
interface alu_operand_loader_if;
  import cpu_types_pkg::*;

  word_t                alu_porta;
  word_t                alu_portb;
  aluop_t               alu_op;
  word_t                alu_outport;
  logic [c_FLAG_W-1:0]  alu_flags;

  modport master (
    output alu_porta,
    output alu_portb,
    output alu_op,
    input  alu_outport,
    input  alu_flags
  );

  modport slave (
    input  alu_porta,
    input  alu_portb,
    input  alu_op,
    output alu_outport,
    output alu_flags
  );

endinterface
`default_nettype wire

// File: rtl/alu_operand_loader_key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : synchronizes and debounces one active-low push-button
// Rev 1.0
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire  CLOCK_50,
  input  wire  RST,
  input  wire  key_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         r_sync;
  logic               r_level;
  logic               r_pulse;
  logic [c_CNT_W-1:0] r_cnt;

  // Counter only runs while the synchronized level disagrees with the
  // accepted one, so any bounce back to the accepted level restarts it.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], ~key_n};
      r_pulse <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_cnt == c_CNT_MAX) begin
          r_level <= r_sync[1];
          r_pulse <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pressed     = r_level;
  assign press_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// alu_operand_loader : button-driven operand/opcode entry sequencer for ALU
// Rev 1.0
// ============================================================================
module alu_operand_loader
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NKEYS           = 2
) (
  input  wire                 CLOCK_50,
  input  wire                 RST,
  input  wire  [NKEYS-1:0]    key_n,
  input  wire  [15:0]         sw_data,
  input  wire  [3:0]          sw_op,
  alu_operand_loader_if.master alu,
  output word_t               result,
  output logic [c_FLAG_W-1:0] flags,
  output logic                done,
  output logic [2:0]          state
);

  logic [NKEYS-1:0] w_pressed;
  logic [NKEYS-1:0] w_pulse;
  logic             w_step;
  logic             w_clr;

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .CLOCK_50   (CLOCK_50),
        .RST        (RST),
        .key_n      (key_n[gi]),
        .pressed    (w_pressed[gi]),
        .press_pulse(w_pulse[gi])
      );
    end
  endgenerate

  assign w_step = w_pulse[0] & w_pressed[0];
  assign w_clr  = w_pulse[1] & w_pressed[1];

  loader_state_t       r_state;
  loader_state_t       w_next;
  word_t               r_porta;
  word_t               r_portb;
  aluop_t              r_op;
  word_t               r_result;
  logic [c_FLAG_W-1:0] r_flags;
  logic                r_done;

  always_ff @(posedge CLOCK_50) begin
    if (RST) r_state <= ST_A_LO;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_A_LO: if (w_step) w_next = ST_A_HI;
      ST_A_HI: if (w_step) w_next = ST_B_LO;
      ST_B_LO: if (w_step) w_next = ST_B_HI;
      ST_B_HI: if (w_step) w_next = ST_OP;
      ST_OP:   if (w_step) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_SHOW;
      ST_SHOW: if (w_step) w_next = ST_A_LO;
      default: w_next = ST_A_LO;
    endcase
    if (w_clr) w_next = ST_A_LO;
  end

  // Clear takes priority over step and over the EXEC capture.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_porta  <= '0;
      r_portb  <= '0;
      r_op     <= ALU_ADD;
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
    end else if (w_clr) begin
      r_porta <= '0;
      r_portb <= '0;
      r_op    <= ALU_ADD;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_A_LO: if (w_step) r_porta[15:0]  <= sw_data;
        ST_A_HI: if (w_step) r_porta[31:16] <= sw_data;
        ST_B_LO: if (w_step) r_portb[15:0]  <= sw_data;
        ST_B_HI: if (w_step) r_portb[31:16] <= sw_data;
        ST_OP:   if (w_step) r_op           <= aluop_t'(sw_op);
        ST_EXEC: begin
          r_result <= alu.alu_outport;
          r_flags  <= alu.alu_flags;
          r_done   <= 1'b1;
        end
        ST_SHOW: if (w_step) r_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign alu.alu_porta = r_porta;
  assign alu.alu_portb = r_portb;
  assign alu.alu_op    = r_op;
  assign result        = r_result;
  assign flags         = r_flags;
  assign done          = r_done;
  assign state         = r_state;

endmodule
`default_nettype wire
